// File: rtl/grf_wb_arb.sv
// Writeback arbiter/load aligner: ALU wins, loads queue (DEPTH) and pop when ALU idle; 1-cycle registered write port.
// Loads backpressured by registered o_ld_ready (!full); ALU never stalls. Define WB_PENDING_EN for o_pending tracking.
module grf_wb_arb #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_b,
  input  logic        i_clk_en,
  input  logic        i_alu_valid,
  input  logic [3:0]  i_alu_waddr,
  input  logic [31:0] i_alu_data,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [3:0]  i_ld_waddr,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_boff,
  input  logic        i_ld_sext,
  input  logic [31:0] i_ld_data,
  output logic [3:0]  o_waddr,
  output logic [3:0]  o_wen,
  output logic [31:0] o_din,
  output logic        o_cs_b,
  output logic [15:0] o_pending
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] q_vld;
  logic [3:0]       q_waddr [DEPTH];
  logic [31:0]      q_data  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             push, pop, head_vld;
  logic [31:0]      ld_shifted, ld_aligned;

  always_comb begin
    ld_shifted = '0;
    ld_aligned = i_ld_data;
    case (i_ld_size)
      2'd0: begin
        ld_shifted = i_ld_data >> {i_ld_boff, 3'b000};
        ld_aligned = {{24{i_ld_sext & ld_shifted[7]}}, ld_shifted[7:0]};
      end
      2'd1: begin
        ld_shifted = i_ld_data >> {i_ld_boff[1], 4'b0000};
        ld_aligned = {{16{i_ld_sext & ld_shifted[15]}}, ld_shifted[15:0]};
      end
      default: ld_aligned = i_ld_data;
    endcase
  end

  // Ready comes from the registered count, so a full FIFO refuses a push even on a popping cycle.
  assign push      = i_clk_en & i_ld_valid & o_ld_ready;
  assign pop       = i_clk_en & ~i_alu_valid & (count != '0);
  assign head_vld  = q_vld[rd_ptr];
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_ld_ready <= 1'b1;
      q_vld      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_waddr[i] <= '0;
        q_data[i]  <= '0;
      end
    end else if (i_clk_en) begin
      // WAW squash precedes the push below, so a same-cycle load (younger) stays valid.
      if (i_alu_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_waddr[i] == i_alu_waddr) q_vld[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + AW'(1);
      end
      if (push) begin
        q_vld[wr_ptr]   <= 1'b1;
        q_waddr[wr_ptr] <= i_ld_waddr;
        q_data[wr_ptr]  <= ld_aligned;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      count      <= count_nxt;
      o_ld_ready <= (count_nxt != FULL);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      o_cs_b  <= 1'b1;
      o_wen   <= 4'h0;
      o_waddr <= 4'h0;
      o_din   <= 32'h0;
    end else if (i_clk_en) begin
      if (i_alu_valid) begin
        o_cs_b  <= 1'b0;
        o_wen   <= 4'hF;
        o_waddr <= i_alu_waddr;
        o_din   <= i_alu_data;
      end else if (count != '0 && head_vld) begin
        o_cs_b  <= 1'b0;
        o_wen   <= 4'hF;
        o_waddr <= q_waddr[rd_ptr];
        o_din   <= q_data[rd_ptr];
      end else begin
        o_cs_b <= 1'b1;
        o_wen  <= 4'h0;
      end
    end
  end

`ifdef WB_PENDING_EN
  // q_vld is cleared on pop and squash, so it marks exactly the live queued writes.
  always_comb begin
    o_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) o_pending[q_waddr[i]] = 1'b1;
    end
  end
`else
  assign o_pending = 16'h0;
`endif

endmodule
